// File: rtl/mac_ctrl_pkg.sv
// Shared constants, mode encoding, sequencer state and row-context types for the MAC control path.
package mac_ctrl_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned VOL_W  = 8;
  localparam int unsigned ROWS_W = ADDR_W + 1;
  localparam int unsigned STEP_W = 4;

  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_ISSUE,
    SEQ_WAIT_ROW,
    SEQ_GAP,
    SEQ_DONE
  } seq_state_e;

  // Working context of the command currently being issued row by row.
  typedef struct packed {
    logic              mode;
    logic [ADDR_W-1:0] addr;
    logic [VOL_W-1:0]  vol;
    logic [STEP_W-1:0] step;
    logic [ROWS_W-1:0] rows_left;
  } mac_row_t;

  // DAC code increment that clamps at full scale instead of wrapping.
  function automatic logic [VOL_W-1:0] vol_sat_add(input logic [VOL_W-1:0]  vol,
                                                   input logic [STEP_W-1:0] step);
    logic [VOL_W:0] sum;
    sum = {1'b0, vol} + (VOL_W + 1)'(step);
    return sum[VOL_W] ? {VOL_W{1'b1}} : sum[VOL_W-1:0];
  endfunction

endpackage

// File: rtl/mac_row_sequencer_if.sv
// Command, WL-control job and status signals of the MAC row sequencer.
// master: command source / WL control side; slave: the sequencer.
interface mac_row_sequencer_if;
  import mac_ctrl_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_mode;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ROWS_W-1:0] cmd_rows;
  logic [VOL_W-1:0]  cmd_vol;
  logic [STEP_W-1:0] cmd_vol_step;
  logic              seq_abort;

  logic              work_en;
  logic              work_mode;
  logic [ADDR_W-1:0] wl_addr_in;
  logic [VOL_W-1:0]  wl_digital_vol_in;
  logic              op_down_com;
  logic              read_down;

  logic              seq_busy;
  logic              seq_done;
  logic              seq_aborted;
  logic              seq_err;

  modport master (
    output cmd_valid, cmd_mode, cmd_addr, cmd_rows, cmd_vol, cmd_vol_step, seq_abort,
           op_down_com, read_down,
    input  cmd_ready, work_en, work_mode, wl_addr_in, wl_digital_vol_in,
           seq_busy, seq_done, seq_aborted, seq_err
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_addr, cmd_rows, cmd_vol, cmd_vol_step, seq_abort,
           op_down_com, read_down,
    output cmd_ready, work_en, work_mode, wl_addr_in, wl_digital_vol_in,
           seq_busy, seq_done, seq_aborted, seq_err
  );

endinterface

// File: rtl/mac_seq_wdt.sv
// Per-row completion watchdog: counts cycles while run is high and flags the last allowed cycle.
module mac_seq_wdt #(
  parameter int unsigned WDT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic timeout_c
);

  localparam int unsigned CNT_W = (WDT_CYC > 1) ? $clog2(WDT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign timeout_c = run && (cnt_q == CNT_W'(WDT_CYC - 1));

  // Restarts from zero every time the row wait is (re)entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!run) begin
      cnt_q <= '0;
    end else if (!timeout_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mac_row_sequencer.sv
// Splits one multi-row MAC command into single-row WL-control jobs, waiting for each row to finish.
// Define MAC_SEQ_WDT_EN to add the per-row completion watchdog (WDT_CYC) and the sticky seq_err flag.
module mac_row_sequencer
  import mac_ctrl_pkg::*;
#(
  parameter int unsigned GAP_CYC = 4
`ifdef MAC_SEQ_WDT_EN
  , parameter int unsigned WDT_CYC = 255
`endif
) (
  input logic                sys_clk,
  input logic                sys_rst_n,
  mac_row_sequencer_if.slave bus
);

  localparam int unsigned GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned GAP_LOAD = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  seq_state_e       state_q, state_d;
  mac_row_t         row_q, row_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             abort_pend_q, abort_pend_d;
  logic             aborted_d;
  logic             row_done_c;
  logic             abort_any_c;
  logic             wdt_timeout_c;

  logic cmd_ready_q, work_en_q, seq_busy_q, seq_done_q, seq_aborted_q;

  // Only the completion matching the row's direction ends it.
  assign row_done_c  = (row_q.mode == MODE_WRITE) ? bus.op_down_com : bus.read_down;
  assign abort_any_c = abort_pend_q | bus.seq_abort;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= SEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    gap_cnt_d    = gap_cnt_q;
    abort_pend_d = abort_pend_q;
    aborted_d    = 1'b0;

    unique case (state_q)
      SEQ_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          row_d.mode      = bus.cmd_mode;
          row_d.addr      = bus.cmd_addr;
          row_d.vol       = bus.cmd_vol;
          row_d.step      = bus.cmd_vol_step;
          row_d.rows_left = (bus.cmd_rows == '0) ? ROWS_W'(1) : bus.cmd_rows;
          abort_pend_d    = 1'b0;
          state_d         = SEQ_ISSUE;
        end
      end

      SEQ_ISSUE: begin
        abort_pend_d = abort_any_c;
        state_d      = SEQ_WAIT_ROW;
      end

      SEQ_WAIT_ROW: begin
        abort_pend_d = abort_any_c;
        if (row_done_c) begin
          if ((row_q.rows_left == ROWS_W'(1)) || abort_any_c) begin
            aborted_d = abort_any_c && (row_q.rows_left != ROWS_W'(1));
            state_d   = SEQ_DONE;
          end else begin
            row_d.addr      = row_q.addr + ADDR_W'(1);
            row_d.vol       = vol_sat_add(row_q.vol, row_q.step);
            row_d.rows_left = row_q.rows_left - ROWS_W'(1);
            gap_cnt_d       = GAP_W'(GAP_LOAD);
            state_d         = SEQ_GAP;
          end
        end else if (wdt_timeout_c) begin
          aborted_d = 1'b1;
          state_d   = SEQ_DONE;
        end
      end

      // The previous row is already complete here, so an abort ends the command at once.
      SEQ_GAP: begin
        if (abort_any_c) begin
          aborted_d = 1'b1;
          state_d   = SEQ_DONE;
        end else if (gap_cnt_q == '0) begin
          state_d = SEQ_ISSUE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      SEQ_DONE: begin
        state_d = SEQ_IDLE;
      end

      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      row_q         <= '0;
      gap_cnt_q     <= '0;
      abort_pend_q  <= 1'b0;
      cmd_ready_q   <= 1'b1;
      work_en_q     <= 1'b0;
      seq_busy_q    <= 1'b0;
      seq_done_q    <= 1'b0;
      seq_aborted_q <= 1'b0;
    end else begin
      row_q         <= row_d;
      gap_cnt_q     <= gap_cnt_d;
      abort_pend_q  <= abort_pend_d;
      cmd_ready_q   <= (state_d == SEQ_IDLE);
      work_en_q     <= (state_d == SEQ_ISSUE);
      seq_busy_q    <= (state_d == SEQ_ISSUE) || (state_d == SEQ_WAIT_ROW) || (state_d == SEQ_GAP);
      seq_done_q    <= (state_d == SEQ_DONE);
      seq_aborted_q <= aborted_d;
    end
  end

`ifdef MAC_SEQ_WDT_EN
  logic wdt_run_c;
  logic seq_err_q;

  assign wdt_run_c = (state_q == SEQ_WAIT_ROW);

  mac_seq_wdt #(
    .WDT_CYC (WDT_CYC)
  ) u_wdt (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .run       (wdt_run_c),
    .timeout_c (wdt_timeout_c)
  );

  // Sticky until reset; a completion in the timeout cycle still wins.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      seq_err_q <= 1'b0;
    end else if (wdt_run_c && wdt_timeout_c && !row_done_c) begin
      seq_err_q <= 1'b1;
    end
  end

  assign bus.seq_err = seq_err_q;
`else
  assign wdt_timeout_c = 1'b0;
  assign bus.seq_err   = 1'b0;
`endif

  assign bus.cmd_ready         = cmd_ready_q;
  assign bus.work_en           = work_en_q;
  assign bus.work_mode         = row_q.mode;
  assign bus.wl_addr_in        = row_q.addr;
  assign bus.wl_digital_vol_in = row_q.vol;
  assign bus.seq_busy          = seq_busy_q;
  assign bus.seq_done          = seq_done_q;
  assign bus.seq_aborted       = seq_aborted_q;

endmodule

// File: tb/tb_mac_row_sequencer.sv
// Self-checking bench for mac_row_sequencer: a WL-control responder plus a per-row arithmetic reference model.
// Build with MAC_SEQ_WDT_EN defined to exercise the watchdog instead of the indefinite row wait.
module tb_mac_row_sequencer;
  import mac_ctrl_pkg::*;

  localparam int unsigned GAP_CYC = 4;
  localparam int          MAX_CYC = 2000;
  localparam int unsigned OBS_W   = ADDR_W + VOL_W + 7;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  int   checks = 0;
  int   errors = 0;
  bit   exp_err = 1'b0;

  mac_row_sequencer_if bus ();

  mac_row_sequencer #(
    .GAP_CYC (GAP_CYC)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic idle_inputs();
    bus.cmd_valid    = 1'b0;
    bus.cmd_mode     = 1'b0;
    bus.cmd_addr     = '0;
    bus.cmd_rows     = '0;
    bus.cmd_vol      = '0;
    bus.cmd_vol_step = '0;
    bus.seq_abort    = 1'b0;
    bus.op_down_com  = 1'b0;
    bus.read_down    = 1'b0;
  endtask

  // Issues one command, plays WL control, and checks every row job and the final status.
  task automatic run_cmd(input string name, input logic mode, input int addr, input int rows,
                         input int vol, input int step, input int fixed_delay,
                         input int abort_row, input bit abort_same, input bit junk);
    int rows_eff, exp_rows, n_issued, cyc, exp_we, last_done, due, abort_at, exp_addr, exp_vol;
    bit done_seen, exp_aborted;
    rows_eff    = (rows == 0) ? 1 : rows;
    exp_aborted = (abort_row > 0) && (abort_row < rows_eff);
    exp_rows    = exp_aborted ? abort_row : rows_eff;
    n_issued = 0; cyc = 0; exp_we = 1; last_done = 0; due = -1; abort_at = -1;
    exp_addr = addr; exp_vol = vol; done_seen = 1'b0;

    @(negedge sys_clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s cmd_ready_idle: got %b want 1", name, bus.cmd_ready);
    end
    bus.seq_abort    = 1'b0;
    bus.cmd_valid    = 1'b1;
    bus.cmd_mode     = mode;
    bus.cmd_addr     = ADDR_W'(addr);
    bus.cmd_rows     = ROWS_W'(rows);
    bus.cmd_vol      = VOL_W'(vol);
    bus.cmd_vol_step = STEP_W'(step);

    while (!done_seen && cyc < MAX_CYC) begin
      @(negedge sys_clk);
      cyc++;
      bus.cmd_valid = 1'b0; bus.op_down_com = 1'b0; bus.read_down = 1'b0; bus.seq_abort = 1'b0;

      if (bus.work_en === 1'b1) begin
        exp_addr = (addr + n_issued) % 32;
        exp_vol  = vol + n_issued * step;
        if (exp_vol > 255) exp_vol = 255;
        n_issued++;
        checks++;
        if (cyc != exp_we) begin
          errors++; $display("FAIL %s work_en_cycle row %0d: got %0d want %0d", name, n_issued, cyc, exp_we);
        end
        checks++;
        if (bus.wl_addr_in !== ADDR_W'(exp_addr)) begin
          errors++; $display("FAIL %s addr row %0d: got %0d want %0d", name, n_issued, bus.wl_addr_in, exp_addr);
        end
        checks++;
        if (bus.wl_digital_vol_in !== VOL_W'(exp_vol)) begin
          errors++; $display("FAIL %s vol row %0d: got %0h want %0h", name, n_issued, bus.wl_digital_vol_in, exp_vol);
        end
        checks++;
        if (bus.work_mode !== mode || bus.seq_busy !== 1'b1) begin
          errors++; $display("FAIL %s mode_busy row %0d: got %b%b want %b1", name, n_issued, bus.work_mode, bus.seq_busy, mode);
        end
        due = cyc + ((fixed_delay > 0) ? fixed_delay : int'($urandom_range(20, 2)));
        if (n_issued == abort_row && !abort_same) abort_at = cyc + 1;
      end

      if (bus.seq_done === 1'b1) begin
        done_seen = 1'b1;
        checks++;
        if (cyc != last_done + 1) begin
          errors++; $display("FAIL %s done_cycle: got %0d want %0d", name, cyc, last_done + 1);
        end
        checks++;
        if (n_issued != exp_rows) begin
          errors++; $display("FAIL %s rows_issued: got %0d want %0d", name, n_issued, exp_rows);
        end
        checks++;
        if (bus.seq_aborted !== exp_aborted) begin
          errors++; $display("FAIL %s seq_aborted: got %b want %b", name, bus.seq_aborted, exp_aborted);
        end
        checks++;
        if (bus.seq_busy !== 1'b0 || bus.cmd_ready !== 1'b0) begin
          errors++; $display("FAIL %s done_busy_ready: got %b%b want 00", name, bus.seq_busy, bus.cmd_ready);
        end
        checks++;
        if (bus.seq_err !== exp_err) begin
          errors++; $display("FAIL %s seq_err: got %b want %b", name, bus.seq_err, exp_err);
        end
      end

      if (!done_seen) begin
        if (cyc == abort_at) bus.seq_abort = 1'b1;
        if (cyc == due) begin
          checks++;
          if (bus.wl_addr_in !== ADDR_W'(exp_addr) || bus.wl_digital_vol_in !== VOL_W'(exp_vol)) begin
            errors++; $display("FAIL %s hold row %0d: got %0d/%0h want %0d/%0h", name, n_issued,
                               bus.wl_addr_in, bus.wl_digital_vol_in, exp_addr, exp_vol);
          end
          if (mode) bus.op_down_com = 1'b1; else bus.read_down = 1'b1;
          if (abort_same && n_issued == abort_row) bus.seq_abort = 1'b1;
          last_done = cyc; exp_we = cyc + int'(GAP_CYC) + 1; due = -1;
        end else if (junk) begin
          if ($urandom_range(2, 0) == 0) begin
            if (mode) bus.read_down = 1'b1; else bus.op_down_com = 1'b1;
          end
          if (last_done > 0 && cyc > last_done && cyc <= exp_we && $urandom_range(1, 0) == 1) begin
            if (mode) bus.op_down_com = 1'b1; else bus.read_down = 1'b1;
          end
          if ($urandom_range(3, 0) == 0) begin
            bus.cmd_valid    = 1'b1;
            bus.cmd_mode     = 1'($urandom);
            bus.cmd_addr     = ADDR_W'($urandom);
            bus.cmd_rows     = ROWS_W'($urandom);
            bus.cmd_vol      = VOL_W'($urandom);
            bus.cmd_vol_step = STEP_W'($urandom);
            checks++;
            if (bus.cmd_ready !== 1'b0) begin
              errors++; $display("FAIL %s cmd_ready_busy cycle %0d: got %b want 0", name, cyc, bus.cmd_ready);
            end
          end
        end
      end
    end

    idle_inputs();
    checks++;
    if (!done_seen) begin
      errors++; $display("FAIL %s timeout: no seq_done within %0d cycles", name, MAX_CYC);
    end else begin
      @(negedge sys_clk);
      if (bus.cmd_ready !== 1'b1 || bus.seq_done !== 1'b0) begin
        errors++; $display("FAIL %s after_done: got ready=%b done=%b want ready=1 done=0", name, bus.cmd_ready, bus.seq_done);
      end
    end
  endtask

  task automatic test_reset();
    logic [OBS_W-1:0] obs, exp_v;
    exp_v = '0;
    exp_v[OBS_W-1] = 1'b1;
    idle_inputs();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    obs = {bus.cmd_ready, bus.work_en, bus.work_mode, bus.wl_addr_in, bus.wl_digital_vol_in,
           bus.seq_busy, bus.seq_done, bus.seq_aborted, bus.seq_err};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL reset_held outputs: got %h want %h", obs, exp_v);
    end
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    obs = {bus.cmd_ready, bus.work_en, bus.work_mode, bus.wl_addr_in, bus.wl_digital_vol_in,
           bus.seq_busy, bus.seq_done, bus.seq_aborted, bus.seq_err};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL reset_released outputs: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_write_basic();
    run_cmd("write_basic", MODE_WRITE, 3, 4, 'h40, 2, 20, 0, 1'b0, 1'b0);
  endtask

  task automatic test_read_wrap();
    run_cmd("read_wrap", MODE_READ, 30, 4, 'h10, 1, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_vol_saturate();
    run_cmd("vol_saturate", MODE_WRITE, 9, 3, 'hFD, 4, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    run_cmd("abort_mid", MODE_WRITE, 10, 8, 'h20, 3, 10, 2, 1'b0, 1'b0);
    run_cmd("abort_same_cycle", MODE_READ, 0, 5, 'h00, 7, 0, 3, 1'b1, 1'b0);
    run_cmd("abort_last_row", MODE_WRITE, 20, 3, 'h55, 1, 0, 3, 1'b0, 1'b0);
    @(negedge sys_clk);
    bus.seq_abort = 1'b1;
    @(negedge sys_clk);
    bus.seq_abort = 1'b0;
    run_cmd("abort_idle", MODE_READ, 5, 3, 'h70, 2, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_rows_zero_busy_cmd();
    run_cmd("rows_zero", MODE_WRITE, 12, 0, 'h80, 5, 0, 0, 1'b0, 1'b1);
    run_cmd("rows_max", MODE_READ, 17, 32, 'hE0, 1, 2, 0, 1'b0, 1'b1);
  endtask

  task automatic test_long_wait();
`ifdef MAC_SEQ_WDT_EN
    int  cyc, extra_we;
    bit  done_seen;
    cyc = 0; extra_we = 0; done_seen = 1'b0;
    @(negedge sys_clk);
    bus.cmd_valid = 1'b1; bus.cmd_mode = MODE_WRITE; bus.cmd_addr = ADDR_W'(1);
    bus.cmd_rows = ROWS_W'(3); bus.cmd_vol = VOL_W'('h10); bus.cmd_vol_step = STEP_W'(1);
    @(negedge sys_clk);
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.work_en !== 1'b1) begin
      errors++; $display("FAIL wdt work_en: got %b want 1", bus.work_en);
    end
    while (!done_seen && cyc < 400) begin
      @(negedge sys_clk);
      cyc++;
      if (bus.work_en === 1'b1) extra_we++;
      if (bus.seq_done === 1'b1) begin
        done_seen = 1'b1;
        checks++;
        if (cyc != 256) begin
          errors++; $display("FAIL wdt done_cycle: got %0d want 256", cyc);
        end
        checks++;
        if (bus.seq_aborted !== 1'b1 || bus.seq_err !== 1'b1) begin
          errors++; $display("FAIL wdt flags: got aborted=%b err=%b want 1 1", bus.seq_aborted, bus.seq_err);
        end
      end
    end
    checks++;
    if (!done_seen || extra_we != 0) begin
      errors++; $display("FAIL wdt end: got done=%b extra_work_en=%0d want done=1 extra=0", done_seen, extra_we);
    end
    exp_err = 1'b1;
    run_cmd("wdt_sticky", MODE_READ, 4, 2, 'h30, 2, 0, 0, 1'b0, 1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    exp_err = 1'b0;
    checks++;
    if (bus.seq_err !== 1'b0) begin
      errors++; $display("FAIL wdt err_cleared: got %b want 0", bus.seq_err);
    end
`else
    run_cmd("long_wait", MODE_WRITE, 2, 2, 'h08, 8, 300, 0, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_random();
    int  rows, rows_eff, abort_row;
    for (int n = 0; n < 15; n++) begin
      rows      = int'($urandom_range(32, 0));
      rows_eff  = (rows == 0) ? 1 : rows;
      abort_row = ($urandom_range(2, 0) == 0) ? int'($urandom_range(rows_eff, 1)) : 0;
      run_cmd($sformatf("random_%0d", n), 1'($urandom), int'($urandom_range(31, 0)), rows,
              int'($urandom_range(255, 0)), int'($urandom_range(15, 0)), 0, abort_row,
              1'($urandom), 1'b1);
    end
  endtask

  task automatic test_reset_mid_row();
    logic [OBS_W-1:0] obs, exp_v;
    bit seen;
    exp_v = '0;
    exp_v[OBS_W-1] = 1'b1;
    seen = 1'b0;
    @(negedge sys_clk);
    bus.cmd_valid = 1'b1; bus.cmd_mode = MODE_WRITE; bus.cmd_addr = ADDR_W'(7);
    bus.cmd_rows = ROWS_W'(5); bus.cmd_vol = VOL_W'('h33); bus.cmd_vol_step = STEP_W'(1);
    @(negedge sys_clk);
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.work_en !== 1'b1) begin
      errors++; $display("FAIL reset_mid work_en: got %b want 1", bus.work_en);
    end
    repeat (3) @(negedge sys_clk);
    #1 sys_rst_n = 1'b0;
    #1;
    obs = {bus.cmd_ready, bus.work_en, bus.work_mode, bus.wl_addr_in, bus.wl_digital_vol_in,
           bus.seq_busy, bus.seq_done, bus.seq_aborted, bus.seq_err};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL reset_mid outputs: got %h want %h", obs, exp_v);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      bus.op_down_com = (i == 2);
      if (bus.work_en === 1'b1 || bus.seq_done === 1'b1) seen = 1'b1;
    end
    bus.op_down_com = 1'b0;
    checks++;
    if (seen || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid job_dropped: got activity=%b ready=%b want 0 1", seen, bus.cmd_ready);
    end
    run_cmd("after_reset", MODE_READ, 31, 2, 'hFF, 15, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_wrap();
    test_vol_saturate();
    test_abort();
    test_rows_zero_busy_cmd();
    test_long_wait();
    test_random();
    test_reset_mid_row();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
